// File: rtl/td4_sequencer.sv
// td4_sequencer: multi-cycle control unit for the 4-bit TD4 core.
// Owns the PC and carry flag, fetches instructions from program ROM over a
// req/ack handshake and decodes them into one-cycle datapath strobes.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for run (free-run) or a step pulse (single instruction)
// FETCH  | rom_req high, rom_addr = pc, waiting for rom_ack or timeout
// EXEC   | single cycle: strobes decoded from ir, pc and carry updated
// FAULT  | ROM never answered; sticky until reset, pc and carry frozen
module td4_sequencer #(
    parameter int PC_W    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            run_i,
    input  logic            step_i,
    output logic            rom_req_o,
    output logic [PC_W-1:0] rom_addr_o,
    input  logic            rom_ack_i,
    input  logic [7:0]      rom_data_i,
    input  logic            alu_carry_i,
    output logic [3:0]      op_o,
    output logic [3:0]      im_o,
    output logic [1:0]      src_sel_o,
    output logic            a_we_o,
    output logic            b_we_o,
    output logic            out_we_o,
    output logic            out_sel_o,
    output logic            carry_o,
    output logic [1:0]      state_o,
    output logic            illegal_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10,
        S_FAULT = 2'b11
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Count of un-acked FETCH cycles at which the next miss trips FAULT
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] SRC_ZERO = 2'b00;
    localparam logic [1:0] SRC_A    = 2'b01;
    localparam logic [1:0] SRC_B    = 2'b10;
    localparam logic [1:0] SRC_IN   = 2'b11;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            carry_q, carry_d;
    logic [7:0]      ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       rom_req;
    logic [1:0] src_sel;
    logic       a_we, b_we, out_we, out_sel, illegal;

    // State, PC, carry, IR and fetch-timeout registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            carry_q <= 1'b0;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            carry_q <= carry_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and EXEC-only instruction decode
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        carry_d = carry_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        rom_req = 1'b0;
        src_sel = SRC_ZERO;
        a_we    = 1'b0;
        b_we    = 1'b0;
        out_we  = 1'b0;
        out_sel = 1'b0;
        illegal = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run_i || step_i) state_d = S_FETCH;
            end

            S_FETCH: begin
                rom_req = 1'b1;
                if (rom_ack_i) begin
                    ir_d    = rom_data_i;
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end else if (cnt_q == CNT_TC) begin
                    cnt_d   = '0;
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_EXEC: begin
                // Defaults for a plain instruction; ADD and jumps override below
                pc_d    = pc_q + PC_W'(1);
                carry_d = 1'b0;
                state_d = run_i ? S_FETCH : S_IDLE;
                case (ir_q[7:4])
                    4'b0000: begin src_sel = SRC_A;    a_we = 1'b1; carry_d = alu_carry_i; end
                    4'b0101: begin src_sel = SRC_B;    b_we = 1'b1; carry_d = alu_carry_i; end
                    4'b0011: begin src_sel = SRC_ZERO; a_we = 1'b1; end
                    4'b0111: begin src_sel = SRC_ZERO; b_we = 1'b1; end
                    4'b0001: begin src_sel = SRC_B;    a_we = 1'b1; end
                    4'b0100: begin src_sel = SRC_A;    b_we = 1'b1; end
                    4'b0010: begin src_sel = SRC_IN;   a_we = 1'b1; end
                    4'b0110: begin src_sel = SRC_IN;   b_we = 1'b1; end
                    4'b1001: begin out_we = 1'b1; out_sel = 1'b0; end
                    4'b1011: begin out_we = 1'b1; out_sel = 1'b1; end
                    4'b1111: pc_d = PC_W'(ir_q[3:0]);
                    // JNC tests the flag left by the previous instruction
                    4'b1110: if (!carry_q) pc_d = PC_W'(ir_q[3:0]);
                    default: illegal = 1'b1;
                endcase
            end

            S_FAULT: begin
                state_d = S_FAULT;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign rom_req_o  = rom_req;
    assign rom_addr_o = pc_q;
    assign op_o       = ir_q[7:4];
    assign im_o       = ir_q[3:0];
    assign src_sel_o  = src_sel;
    assign a_we_o     = a_we;
    assign b_we_o     = b_we;
    assign out_we_o   = out_we;
    assign out_sel_o  = out_sel;
    assign carry_o    = carry_q;
    assign state_o    = state_q;
    assign illegal_o  = illegal;

endmodule
